// File: rtl/pattern_stamper_pkg.sv
// pattern_stamper_pkg: board geometry, shared types and address helpers for pattern_stamper.
package pattern_stamper_pkg;
  localparam int BOARD_W = 96;
  localparam int BOARD_H = 16;
  localparam int WORD_W = 32;
  localparam int WORDS_PER_ROW = BOARD_W / WORD_W;
  localparam int PAT_SIZE = 8;
  localparam int N_WORDS = BOARD_H * WORDS_PER_ROW;
  localparam int SH_W = $clog2(WORD_W);
  // Distinct lo/hi words and 8 distinct rows keep every stamp address unique.
  localparam bit GEOM_OK = WORDS_PER_ROW >= 2 && BOARD_H >= PAT_SIZE && BOARD_W % WORD_W == 0;
  typedef logic [$clog2(BOARD_W)-1:0] pos_t;
  typedef logic [$clog2(N_WORDS)-1:0] addr_t;
  typedef logic [WORD_W-1:0] data_t;
  typedef logic [2:0] pat_sel_t;
  function automatic pos_t wrap_inc(pos_t v, int lim);
    return (v == pos_t'(lim - 1)) ? '0 : v + 1'b1;
  endfunction
  function automatic addr_t word_addr(pos_t y, pos_t w);
    return addr_t'(y * WORDS_PER_ROW + w);
  endfunction
  function automatic data_t merge(data_t d, data_t m, logic erase);
    return erase ? (d & ~m) : (d | m);
  endfunction
endpackage

// File: rtl/pattern_stamper_if.sv
// pattern_stamper_if: request and memory-port bundle; erase_in exists only with PATTERN_STAMPER_ERASE_EN.
interface pattern_stamper_if;
  import pattern_stamper_pkg::*;
  logic start_in;
  pat_sel_t pattern_sel_in;
  pos_t cursor_x_in;
  pos_t cursor_y_in;
  data_t data_r_in;
  addr_t addr_r_out;
  addr_t addr_w_out;
  data_t data_w_out;
  logic wr_en_out;
  logic busy_out;
  logic done_out;
`ifdef PATTERN_STAMPER_ERASE_EN
  logic erase_in;
  modport master (output start_in, pattern_sel_in, cursor_x_in, cursor_y_in, data_r_in, erase_in,
                  input addr_r_out, addr_w_out, data_w_out, wr_en_out, busy_out, done_out);
  modport slave (input start_in, pattern_sel_in, cursor_x_in, cursor_y_in, data_r_in, erase_in,
                 output addr_r_out, addr_w_out, data_w_out, wr_en_out, busy_out, done_out);
`else
  modport master (output start_in, pattern_sel_in, cursor_x_in, cursor_y_in, data_r_in,
                  input addr_r_out, addr_w_out, data_w_out, wr_en_out, busy_out, done_out);
  modport slave (input start_in, pattern_sel_in, cursor_x_in, cursor_y_in, data_r_in,
                 output addr_r_out, addr_w_out, data_w_out, wr_en_out, busy_out, done_out);
`endif
endinterface

// File: rtl/pattern_stamper_rom.sv
// pattern_rom: 8x8 preset pattern rows, byte r of each entry is row r, bit i is column x+i.
module pattern_rom
  import pattern_stamper_pkg::*;
(
  input pat_sel_t sel,
  input logic [2:0] row,
  output logic [7:0] row_bits
);
  localparam logic [63:0] PATS [8] = '{
    64'h0000_0000_0000_0303,
    64'h0000_0000_0000_0007,
    64'h0000_0000_0007_0402,
    64'h0000_0000_0F11_0112,
    64'h0000_0000_0002_0306,
    64'h0000_0000_0006_0906,
    64'h0000_0000_0000_070E,
    64'hFFFF_FFFF_FFFF_FFFF
  };
  assign row_bits = PATS[sel][{row, 3'b000} +: 8];
endmodule

// File: rtl/pattern_stamper.sv
// pattern_stamper: stamps an 8x8 pattern into a toroidal board by word read-modify-write, 4 cycles per row.
// Optional PATTERN_STAMPER_ERASE_EN adds erase_in to clear the pattern cells instead of setting them.
module pattern_stamper
  import pattern_stamper_pkg::*;
(
  input logic clk_in,
  input logic rst_in,
  pattern_stamper_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;
  state_t st;
  pat_sel_t sel;
  logic [2:0] row;
  logic [SH_W-1:0] b;
  pos_t w, wh, yr, x_word;
  logic [7:0] rom_row;
  logic [2*WORD_W-1:0] mask;
  logic last_row;
  logic erase;
  if (!GEOM_OK) begin : g_geom_bad
    $error("pattern_stamper: board geometry too small for an 8x8 stamp");
  end
`ifdef PATTERN_STAMPER_ERASE_EN
  always_ff @(posedge clk_in)
    if (rst_in) erase <= 1'b0;
    else if (st == IDLE && bus.start_in) erase <= bus.erase_in;
`else
  assign erase = 1'b0;
`endif
  pattern_rom u_rom (.sel(sel), .row(row), .row_bits(rom_row));
  assign mask = {{(2*WORD_W-PAT_SIZE){1'b0}}, rom_row} << b;
  assign x_word = pos_t'(bus.cursor_x_in / WORD_W);
  assign last_row = row == 3'(PAT_SIZE - 1);
  // Read data is merged straight into the registered write word, so no separate lo/hi holding registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      st <= IDLE;
      sel <= '0;
      row <= '0;
      b <= '0;
      w <= '0;
      wh <= '0;
      yr <= '0;
      bus.addr_r_out <= '0;
      bus.addr_w_out <= '0;
      bus.data_w_out <= '0;
      bus.wr_en_out <= 1'b0;
      bus.busy_out <= 1'b0;
      bus.done_out <= 1'b0;
    end else begin
      bus.wr_en_out <= 1'b0;
      bus.done_out <= 1'b0;
      case (st)
        IDLE: if (bus.start_in) begin
          st <= RD_LO;
          sel <= bus.pattern_sel_in;
          row <= '0;
          b <= SH_W'(bus.cursor_x_in % WORD_W);
          w <= x_word;
          wh <= wrap_inc(x_word, WORDS_PER_ROW);
          yr <= bus.cursor_y_in;
          bus.addr_r_out <= word_addr(bus.cursor_y_in, x_word);
          bus.busy_out <= 1'b1;
        end
        RD_LO: begin
          st <= RD_HI;
          bus.addr_r_out <= word_addr(yr, wh);
        end
        RD_HI: begin
          st <= WR_LO;
          bus.addr_w_out <= word_addr(yr, w);
          bus.data_w_out <= merge(bus.data_r_in, mask[WORD_W-1:0], erase);
          bus.wr_en_out <= 1'b1;
        end
        WR_LO: begin
          st <= WR_HI;
          bus.addr_w_out <= word_addr(yr, wh);
          bus.data_w_out <= merge(bus.data_r_in, mask[2*WORD_W-1:WORD_W], erase);
          bus.wr_en_out <= |mask[2*WORD_W-1:WORD_W];
        end
        WR_HI: begin
          st <= last_row ? DONE : RD_LO;
          row <= row + 1'b1;
          yr <= wrap_inc(yr, BOARD_H);
          bus.addr_r_out <= word_addr(wrap_inc(yr, BOARD_H), w);
          bus.done_out <= last_row;
        end
        DONE: begin
          st <= IDLE;
          bus.busy_out <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
